// File: rtl/sampler_ctrl.sv
`default_nettype none
// ============================================================================
// sampler_ctrl : UART command sequencer plus reply/sampler TX byte arbiter
// Rev 1.0
// ============================================================================
module sampler_ctrl #(
    parameter int DATA_SIZE      = 8,
    parameter int CMD_PARAM_SIZE = 4
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [DATA_SIZE-1:0]      i_rx_data,
    input  logic                      i_rx_valid,
    output logic                      o_rx_ready,
    output logic                      o_adc_init,
    output logic                      o_sample,
    output logic                      o_cmd_decim,
    output logic [CMD_PARAM_SIZE-1:0] o_cmd_param,
    input  logic [DATA_SIZE-1:0]      i_smp_data,
    input  logic                      i_smp_valid,
    output logic                      o_smp_next,
    input  logic                      i_smp_idle,
    output logic [DATA_SIZE-1:0]      o_tx_data,
    output logic                      o_tx_valid,
    input  logic                      i_tx_ready
);

    typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_ISSUE, ST_REPLY} state_t;
    typedef enum logic [1:0] {ACT_NONE, ACT_INIT, ACT_SAMPLE, ACT_DECIM} act_t;
    typedef enum logic {OWN_SMP, OWN_CTRL} owner_t;

    localparam logic [3:0] OP_STATUS  = 4'h0;
    localparam logic [3:0] OP_INIT    = 4'h1;
    localparam logic [3:0] OP_SAMPLE  = 4'h2;
    localparam logic [3:0] OP_DECIM   = 4'h3;
    localparam logic [3:0] TAG_OK     = 4'hA;
    localparam logic [3:0] TAG_ERR    = 4'hE;
    localparam logic [3:0] TAG_STATUS = 4'h5;

    state_t               state;
    state_t               state_next;
    act_t                 act;
    act_t                 decode_act;
    owner_t               owner;
    logic [DATA_SIZE-1:0] cmd;
    logic [DATA_SIZE-1:0] reply_byte;
    logic [DATA_SIZE-1:0] decode_reply;
    logic [3:0]           opcode;
    logic                 reply_pend;
    logic                 tx_free;
    logic                 reply_done;

    assign opcode = cmd[7:4];

    // Legality of SAMPLE/DECIM is judged on the sampler state seen in DECODE.
    always_comb begin
        decode_act   = ACT_NONE;
        decode_reply = {TAG_ERR, opcode};
        case (opcode)
            OP_STATUS: decode_reply = {TAG_STATUS, 1'b0, o_adc_init, i_smp_idle, i_smp_valid};
            OP_INIT: begin
                decode_act   = ACT_INIT;
                decode_reply = {TAG_OK, opcode};
            end
            OP_SAMPLE: begin
                if (o_adc_init && i_smp_idle) begin
                    decode_act   = ACT_SAMPLE;
                    decode_reply = {TAG_OK, opcode};
                end
            end
            OP_DECIM: begin
                if (i_smp_idle) begin
                    decode_act   = ACT_DECIM;
                    decode_reply = {TAG_OK, opcode};
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        tx_free    = !o_tx_valid || i_tx_ready;
        reply_done = (owner == OWN_CTRL) && o_tx_valid && i_tx_ready;
        o_smp_next = tx_free && !reply_pend && (owner == OWN_SMP);
        state_next = state;
        case (state)
            ST_IDLE:   if (i_rx_valid && o_rx_ready) state_next = ST_DECODE;
            ST_DECODE: state_next = ST_ISSUE;
            ST_ISSUE:  state_next = ST_REPLY;
            ST_REPLY:  if (!reply_pend && reply_done) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            o_rx_ready  <= 1'b0;
            o_adc_init  <= 1'b0;
            o_sample    <= 1'b0;
            o_cmd_decim <= 1'b0;
            o_cmd_param <= '0;
            o_tx_valid  <= 1'b0;
            o_tx_data   <= '0;
            reply_pend  <= 1'b0;
            owner       <= OWN_SMP;
            cmd         <= '0;
            reply_byte  <= '0;
            act         <= ACT_NONE;
        end else begin
            o_rx_ready  <= (state_next == ST_IDLE);
            o_sample    <= 1'b0;
            o_cmd_decim <= 1'b0;

            if (state == ST_IDLE && i_rx_valid && o_rx_ready) begin
                cmd <= i_rx_data;
            end

            if (state == ST_DECODE) begin
                reply_byte <= decode_reply;
                act        <= decode_act;
            end

            if (state == ST_ISSUE) begin
                reply_pend <= 1'b1;
                case (act)
                    ACT_INIT:   o_adc_init <= cmd[0];
                    ACT_SAMPLE: o_sample   <= 1'b1;
                    ACT_DECIM: begin
                        o_cmd_param <= cmd[CMD_PARAM_SIZE-1:0];
                        o_cmd_decim <= 1'b1;
                    end
                    default: ;
                endcase
            end

            // Ownership changes only on a byte boundary; a held byte is never replaced.
            if (tx_free) begin
                if (reply_pend) begin
                    owner      <= OWN_CTRL;
                    o_tx_data  <= reply_byte;
                    o_tx_valid <= 1'b1;
                    reply_pend <= 1'b0;
                end else begin
                    owner <= OWN_SMP;
                    if (i_smp_valid && o_smp_next) begin
                        o_tx_data  <= i_smp_data;
                        o_tx_valid <= 1'b1;
                    end else begin
                        o_tx_valid <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
